// File: rtl/nes_controller_reader.sv
// nes_controller_reader
// Polls an NES controller (4021 shift register) at a fixed rate and publishes
// the eight button states once per complete frame.
//
// Ports
//   clk     : single clock, all logic on the rising edge
//   rst     : synchronous, active-high reset
//   en      : polling enable
//   data    : controller serial line, active-low, asynchronous to clk
//   latch   : latch strobe to the controller
//   pulse   : shift clock to the controller
//   buttons : last complete sample, 1 = pressed
//             (bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down,
//              bit6 Left, bit7 Right)
//   axiov   : one-cycle valid strobe for axiod
//   axiod   : {buttons, buttons}
module nes_controller_reader #(
   parameter int LATCH_CYCLES = 600,
   parameter int HALF_CYCLES  = 300,
   parameter int POLL_CYCLES  = 833_333
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        data,
   output logic        latch,
   output logic        pulse,
   output logic [7:0]  buttons,
   output logic        axiov,
   output logic [15:0] axiod
);

   // One width serves both the phase counter and the poll counter; it holds
   // POLL_CYCLES-1, which is the largest count either of them reaches.
   localparam int PW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;

   localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
   localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYCLES - 1);
   localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
   localparam logic [PW-1:0] CNT_ZERO   = '0;
   localparam logic [PW-1:0] CNT_ONE    = PW'(1'b1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LATCH    = 3'd1,
      WAIT0    = 3'd2,
      PULSE_HI = 3'd3,
      PULSE_LO = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   cnt;
   logic [PW-1:0]   cnt_next;
   logic [PW-1:0]   poll;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic [7:0]      shift_next;
   logic            capture;
   logic            start;
   logic            en_prev;
   logic            data_meta;
   logic            data_sync;

   // Two-flop synchronizer for the asynchronous controller line.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_meta <= 1'b0;
         data_sync <= 1'b0;
      end else begin
         data_meta <= data;
         data_sync <= data_meta;
      end
   end

   // Next-state logic: phase timing, bit capture strobes and frame start.
   always_comb begin
      state_next = state;
      cnt_next   = cnt + CNT_ONE;
      capture    = 1'b0;
      start      = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = CNT_ZERO;
            // A fresh rise of en starts a frame immediately; otherwise the
            // poll counter paces the frames.
            if (en && ((poll == CNT_ZERO) || !en_prev)) begin
               state_next = LATCH;
               start      = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         LATCH: begin
            if (cnt == LATCH_LAST) begin
               state_next = WAIT0;
               cnt_next   = CNT_ZERO;
            end else begin
               state_next = LATCH;
            end
         end
         WAIT0: begin
            // Bit 0 (A) is presented by the controller right after latch.
            if (cnt == HALF_LAST) begin
               capture    = 1'b1;
               state_next = PULSE_HI;
               cnt_next   = CNT_ZERO;
            end else begin
               state_next = WAIT0;
            end
         end
         PULSE_HI: begin
            if (cnt == HALF_LAST) begin
               state_next = PULSE_LO;
               cnt_next   = CNT_ZERO;
            end else begin
               state_next = PULSE_HI;
            end
         end
         PULSE_LO: begin
            if (cnt == HALF_LAST) begin
               capture  = 1'b1;
               cnt_next = CNT_ZERO;
               if (bit_cnt == 3'd7) begin
                  state_next = DONE;
               end else begin
                  state_next = PULSE_HI;
               end
            end else begin
               state_next = PULSE_LO;
            end
         end
         DONE: begin
            state_next = IDLE;
            cnt_next   = CNT_ZERO;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = CNT_ZERO;
         end
      endcase
   end

   // Bits arrive A first; shifting in at the MSB leaves A at bit0 after eight.
   always_comb begin
      if (capture) begin
         shift_next = {~data_sync, shift[7:1]};
      end else begin
         shift_next = shift;
      end
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= CNT_ZERO;
         poll    <= CNT_ZERO;
         bit_cnt <= 3'd0;
         shift   <= 8'h00;
         en_prev <= 1'b0;
         latch   <= 1'b0;
         pulse   <= 1'b0;
         axiov   <= 1'b0;
         buttons <= 8'h00;
         axiod   <= 16'h0000;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         shift   <= shift_next;
         en_prev <= en;

         // Poll counter reads 1 in the first latch cycle, so it is back at 0
         // in the cycle before the next latch rise is due.
         if (start) begin
            poll <= CNT_ONE;
         end else if (poll == POLL_LAST) begin
            poll <= CNT_ZERO;
         end else begin
            poll <= poll + CNT_ONE;
         end

         if (start) begin
            bit_cnt <= 3'd0;
         end else if (capture) begin
            bit_cnt <= bit_cnt + 3'd1;
         end else begin
            bit_cnt <= bit_cnt;
         end

         // Outputs follow the next state so they line up with the state itself.
         latch <= (state_next == LATCH);
         pulse <= (state_next == PULSE_HI);
         axiov <= (state_next == DONE);

         // Publish only a complete frame, including the bit captured this edge.
         if (state_next == DONE) begin
            buttons <= shift_next;
            axiod   <= {shift_next, shift_next};
         end
      end
   end

endmodule

// File: tb/tb_nes_controller_reader.sv
// tb_nes_controller_reader
// Directed bench for nes_controller_reader with L=4, H=2, POLL=64. A small
// behavioural 4021 model drives the serial line from a button pattern.
module tb_nes_controller_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   wire         data;
   logic        latch;
   logic        pulse;
   logic [7:0]  buttons;
   logic        axiov;
   logic [15:0] axiod;

   logic [7:0]  pattern = 8'h00;   // 1 = button pressed
   int          idx     = 0;
   int          checks  = 0;
   int          errors  = 0;

   nes_controller_reader #(
      .LATCH_CYCLES(4),
      .HALF_CYCLES (2),
      .POLL_CYCLES (64)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .data   (data),
      .latch  (latch),
      .pulse  (pulse),
      .buttons(buttons),
      .axiov  (axiov),
      .axiod  (axiod)
   );

   always #5 clk = ~clk;

   // Controller model: latch reloads, each pulse rise shifts one bit onward.
   always @(posedge latch or posedge pulse) begin
      if (latch) idx = 0;
      else if (idx < 7) idx = idx + 1;
   end
   assign data = ~pattern[idx[2:0]];

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected {latch, pulse, axiov} at cycle c of one frame (c=0: first latch cycle).
   function automatic logic [2:0] frame_exp(input int c);
      logic l, p, v;
      l = (c >= 0) && (c <= 3);
      p = (c >= 6) && (c <= 31) && (((c - 6) % 4) < 2);
      v = (c == 34);
      return {l, p, v};
   endfunction

   // Waits for axiov, returning the number of ticks taken; a timeout is a failure.
   task automatic wait_axiov(output int n);
      n = 0;
      while (!axiov && n < 100) begin
         tick();
         n++;
      end
      if (!axiov) check("axiov_timeout", 16'd0, 16'd1);
   endtask

   initial begin
      int n;
      int seen;
      rst = 1'b1;
      en  = 1'b1;
      pattern = 8'h89;          // A, Start, Right pressed
      tick(); tick(); tick();
      check("rst_outputs", {13'd0, latch, pulse, axiov}, 16'd0);
      check("rst_buttons", {8'h00, buttons}, 16'h0000);
      check("rst_axiod", axiod, 16'h0000);

      // Two back-to-back polled frames.
      rst = 1'b0;
      tick();
      for (int c = 0; c < 100; c++) begin
         if (c > 0) tick();
         check("timing", {13'd0, latch, pulse, axiov}, {13'd0, frame_exp(c % 64)});
         if (c == 34 || c == 98) begin
            check("decode_buttons", {8'h00, buttons}, 16'h0089);
            check("decode_axiod", axiod, 16'h8989);
         end
      end

      // en dropped mid-frame: frame completes, then no further polling.
      rst = 1'b1;
      tick();
      check("rst2_buttons", {8'h00, buttons}, 16'h0000);
      check("rst2_outputs", {13'd0, latch, pulse, axiov}, 16'd0);
      rst = 1'b0;
      tick();
      for (int c = 0; c <= 80; c++) begin
         if (c > 0) tick();
         check("en_drop", {13'd0, latch, pulse, axiov}, {13'd0, frame_exp(c)});
         if (c == 10) en = 1'b0;
         if (c == 34) check("en_drop_buttons", {8'h00, buttons}, 16'h0089);
      end
      en = 1'b1;
      tick();
      check("en_rise_latch", {15'd0, latch}, 16'd1);

      // Reset at cycle 20 of this frame.
      for (int c = 1; c <= 20; c++) tick();
      pattern = 8'hFF;
      rst = 1'b1;
      tick();
      check("midrst_outputs", {13'd0, latch, pulse, axiov}, 16'd0);
      check("midrst_buttons", {8'h00, buttons}, 16'h0000);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (axiov) seen++;
      end
      check("midrst_no_axiov", 16'(seen), 16'd0);
      rst = 1'b0;
      tick();
      check("latch_after_rst", {15'd0, latch}, 16'd1);

      // All pressed, then all released on the following poll.
      wait_axiov(n);
      check("pressed_at", 16'(n), 16'd34);
      check("pressed_buttons", {8'h00, buttons}, 16'h00FF);
      check("pressed_axiod", axiod, 16'hFFFF);
      pattern = 8'h00;
      tick();
      check("axiov_one_cycle", {15'd0, axiov}, 16'd0);
      wait_axiov(n);
      check("released_at", 16'(n), 16'd63);
      check("released_buttons", {8'h00, buttons}, 16'h0000);
      check("released_axiod", axiod, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nes_controller_reader.md
NES_CONTROLLER_READER -- requirements
Module: nes_controller_reader

Interface
REQ-001 SHALL have parameter LATCH_CYCLES, default 600, meaning latch high time in clk cycles (12 us at 50 MHz).
REQ-002 SHALL have parameter HALF_CYCLES, default 300, meaning pulse high time and pulse low time in clk cycles (6 us each).
REQ-003 SHALL have parameter POLL_CYCLES, default 833_333, meaning cycles between successive latch rising edges (60 Hz).
REQ-004 SHALL have port clk, input, 1 bit: the single clock (eth_refclk domain, 50 MHz); all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: polling enable.
REQ-007 SHALL have port data, input, 1 bit: controller serial line, active-low (0 = pressed), asynchronous to clk.
REQ-008 SHALL have port latch, output, 1 bit: latch strobe to the controller.
REQ-009 SHALL have port pulse, output, 1 bit: shift clock to the controller.
REQ-010 SHALL have port buttons, output, 8 bits: last complete sample, 1 = pressed; bit0=A, bit1=B, bit2=Select, bit3=Start, bit4=Up, bit5=Down, bit6=Left, bit7=Right.
REQ-011 SHALL have port axiov, output, 1 bit: one-cycle valid strobe for axiod.
REQ-012 SHALL have port axiod, output, 16 bits: {buttons, buttons}, the duplicated byte for the 16-bit network_stack_tx payload.

Function
REQ-013 SHALL pass data through a 2-flop synchronizer; every sample uses the synchronized value.
REQ-014 SHALL implement the states IDLE, LATCH, WAIT0, PULSE_HI, PULSE_LO and DONE.
REQ-015 SHALL move from IDLE to LATCH when en=1 and the poll counter is 0; cycle 0 is defined as the first cycle with latch=1.
REQ-016 SHALL drive latch=1 during cycles 0..L-1 only (L=LATCH_CYCLES, H=HALF_CYCLES).
REQ-017 SHALL hold WAIT0 for cycles L..L+H-1 with pulse=0, and capture bit0 = ~data_sync at cycle L+H-1.
REQ-018 SHALL, for k=1..7, drive pulse=1 for H cycles (PULSE_HI), then pulse=0 for H cycles (PULSE_LO), and capture bit k = ~data_sync on the last PULSE_LO cycle.
REQ-019 SHALL capture the final bit at cycle L+15H-1 and, in DONE at cycle L+15H, update buttons and axiod and assert axiov for exactly 1 cycle.
REQ-020 SHALL update buttons and axiod only in DONE; intermediate bits accumulate in an internal shift register, so a partial frame is never visible.
REQ-021 SHALL run a poll counter that restarts at latch rise and wraps at POLL_CYCLES-1, so consecutive latch rises are exactly POLL_CYCLES apart while en=1.
REQ-022 SHALL, when en falls mid-frame, complete the frame including DONE, then stay in IDLE.
REQ-023 SHALL, when en rises in IDLE, start a frame on the next cycle regardless of the poll counter; the counter then restarts from that latch rise.
REQ-024 SHALL never assert latch and pulse in the same cycle.
REQ-025 SHALL use counters wide enough for POLL_CYCLES-1.
REQ-026 SHALL require POLL_CYCLES > L+15H+1; behaviour for smaller values is undefined.

Reset
REQ-027 SHALL, while rst=1, force latch=0, pulse=0, axiov=0, axiod=0, buttons=0, the shift register and synchronizer to 0, the poll counter to 0, and the state to IDLE.
REQ-028 SHALL, on rst asserted mid-frame, abort the frame with no axiov and no buttons update.
REQ-029 SHALL, if en=1, assert latch on the first cycle after rst deasserts.

Verification (simulation parameters L=4, H=2, POLL=64)
REQ-030 Frame timing: with en=1, latch is high at cycles 0-3; pulse is high at cycles 6-7, 10-11, ..., 30-31 (7 pulses); axiov is high only at cycle 34.
REQ-031 Decode: the model drives data low for bits A, Start and Right, high otherwise -> buttons=8'h89 and axiod=16'h8989 at axiov.
REQ-032 Repeat: the next latch rises at cycle 64; with the model unchanged, a second axiov at cycle 98 carries 16'h8989.
REQ-033 en dropped at cycle 10: the frame finishes with axiov at cycle 34, and latch stays low until en returns; latch rises 1 cycle after en=1.
REQ-034 Reset at cycle 20 mid-frame: latch, pulse and axiov are 0 and buttons is 8'h00; no axiov occurs for the aborted frame, and a new latch appears 1 cycle after rst falls.
REQ-035 All released (data held high): buttons=8'h00, axiod=16'h0000; all pressed (data held low): 8'hFF, 16'hFFFF.
